// File: rtl/fp128_decomp_arbiter.sv
// fp128_decomp_arbiter
// Shares one registered FP128 decompose/classify stage between NREQ requesters.
// A round-robin arbiter picks a requester, an IDLE/EVAL/RESP sequencer enables
// the stage for a single cycle, and the result is returned on a valid/ready
// response channel tagged with the index of the requester that was served.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot or zero)
//   req_op              NREQ packed 128-bit operands, requester k at [128k+:128]
//   rsp_valid/rsp_ready response handshake
//   rsp_tag             index of the served requester
//   rsp_o               operand as accepted
//   rsp_sgn/exp/fract   sign, exponent, {hidden bit, significand}
//   rsp_xz..rsp_nan     class flags
//   busy                sequencer is not idle
module fp128_decomp_arbiter #(
  parameter int NREQ = 4,
  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*128-1:0]   req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAGW-1:0]       rsp_tag,
  output logic [127:0]          rsp_o,
  output logic                  rsp_sgn,
  output logic [14:0]           rsp_exp,
  output logic [112:0]          rsp_fract,
  output logic                  rsp_xz,
  output logic                  rsp_mz,
  output logic                  rsp_vz,
  output logic                  rsp_inf,
  output logic                  rsp_xinf,
  output logic                  rsp_qnan,
  output logic                  rsp_snan,
  output logic                  rsp_nan,
  output logic                  busy
);

  // Padded request vector so a TAGW-bit index always covers it exactly.
  localparam int PADW = 1 << TAGW;
  localparam logic [TAGW-1:0] LAST_IDX = TAGW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Class flags packed as {xz, mz, vz, inf, xinf, qnan, snan, nan}.
  function automatic logic [7:0] classify(input logic [127:0] op);
    logic [14:0]  e;
    logic [111:0] m;
    logic xz, mz, xinf;
    e    = op[126:112];
    m    = op[111:0];
    xz   = (e == 15'd0);
    mz   = (m == 112'd0);
    xinf = &e;
    return {xz, mz, xz & mz, xinf & mz, xinf, xinf & m[111],
            xinf & ~m[111] & ~mz, xinf & ~mz};
  endfunction

  state_t            state_r, state_nxt_s;
  logic [TAGW-1:0]   ptr_r, ptr_nxt_s;
  logic [TAGW-1:0]   tag_r;
  logic [127:0]      op_r;
  logic [PADW-1:0]   valid_pad_s;
  logic [TAGW:0]     cand_s;
  logic [TAGW-1:0]   win_idx_s;
  logic              win_found_s;
  logic              grant_ok_s;
  logic              grant_s;
  logic [NREQ-1:0]   req_ready_s;
  logic [127:0]      op_sel_s;
  logic [7:0]        flags_r;
  logic [TAGW-1:0]   rsp_tag_r;
  logic [127:0]      rsp_o_r;
  logic [112:0]      rsp_fract_r;

  assign valid_pad_s = PADW'(req_valid);

  // Round-robin search: first valid requester starting at ptr_r, wrapping mod NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, ptr_r} + (TAGW+1)'(i);
      if (cand_s >= (TAGW+1)'(NREQ)) begin
        cand_s = cand_s - (TAGW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && valid_pad_s[cand_s[TAGW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[TAGW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grants only in IDLE or while the current response is being accepted; reset blocks them.
  assign grant_ok_s = rst_n && ((state_r == IDLE) || ((state_r == RESP) && rsp_ready));
  assign grant_s    = grant_ok_s && win_found_s;
  assign ptr_nxt_s  = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + TAGW'(1);

  // One-hot ready and AND-OR select of the granted operand.
  always_comb begin
    req_ready_s = '0;
    op_sel_s    = 128'd0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready_s[k] = grant_s && (win_idx_s == TAGW'(k));
      op_sel_s       = op_sel_s | (req_op[k*128 +: 128] & {128{req_ready_s[k]}});
    end
  end

  assign req_ready = req_ready_s;

  // Sequencer next-state: EVAL lasts exactly one cycle and is the stage enable.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_nxt_s = EVAL;
        else         state_nxt_s = IDLE;
      end
      EVAL: state_nxt_s = RESP;
      RESP: begin
        if (!rsp_ready)   state_nxt_s = RESP;
        else if (grant_s) state_nxt_s = EVAL;
        else              state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, arbiter pointer, operand register and decomposed response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      tag_r       <= '0;
      op_r        <= 128'd0;
      rsp_tag_r   <= '0;
      rsp_o_r     <= 128'd0;
      rsp_fract_r <= 113'd0;
      flags_r     <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        ptr_r <= ptr_nxt_s;
        tag_r <= win_idx_s;
        op_r  <= op_sel_s;
      end
      // Response registers only move in EVAL, so they hold through RESP backpressure.
      if (state_r == EVAL) begin
        rsp_tag_r   <= tag_r;
        rsp_o_r     <= op_r;
        rsp_fract_r <= {|op_r[126:112], op_r[111:0]};
        flags_r     <= classify(op_r);
      end
    end
  end

  assign rsp_valid = (state_r == RESP);
  assign busy      = (state_r != IDLE);
  assign rsp_tag   = rsp_tag_r;
  assign rsp_o     = rsp_o_r;
  assign rsp_sgn   = rsp_o_r[127];
  assign rsp_exp   = rsp_o_r[126:112];
  assign rsp_fract = rsp_fract_r;
  assign {rsp_xz, rsp_mz, rsp_vz, rsp_inf, rsp_xinf, rsp_qnan, rsp_snan, rsp_nan} = flags_r;

endmodule

// File: tb/tb_fp128_decomp_arbiter.sv
// Directed testbench for fp128_decomp_arbiter (NREQ = 4).
// Inputs are driven at the falling edge and outputs sampled 1 time unit later.
module tb_fp128_decomp_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_tag;
  logic [127:0] rsp_o;
  logic         rsp_sgn;
  logic [14:0]  rsp_exp;
  logic [112:0] rsp_fract;
  logic         rsp_xz, rsp_mz, rsp_vz, rsp_inf, rsp_xinf, rsp_qnan, rsp_snan, rsp_nan;
  logic         busy;
  logic [7:0]   flags;

  int tests_run;
  int tests_failed;

  fp128_decomp_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_o(rsp_o), .rsp_sgn(rsp_sgn), .rsp_exp(rsp_exp), .rsp_fract(rsp_fract),
    .rsp_xz(rsp_xz), .rsp_mz(rsp_mz), .rsp_vz(rsp_vz), .rsp_inf(rsp_inf),
    .rsp_xinf(rsp_xinf), .rsp_qnan(rsp_qnan), .rsp_snan(rsp_snan), .rsp_nan(rsp_nan),
    .busy(busy)
  );

  assign flags = {rsp_xz, rsp_mz, rsp_vz, rsp_inf, rsp_xinf, rsp_qnan, rsp_snan, rsp_nan};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] op_of(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) req_op[k*128 +: 128] = op_of(k);
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (rsp_o !== 128'd0) begin tests_failed++; $display("FAIL reset_rsp_o: got %h want 0", rsp_o); end
    tests_run++; if (flags !== 8'd0 || rsp_fract !== 113'd0 || rsp_tag !== 2'd0) begin
      tests_failed++; $display("FAIL reset_fields: flags %b fract %h tag %0d want all 0", flags, rsp_fract, rsp_tag); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_op[127:0] = 128'h3FFF_0000_0000_0000_0000_0000_0000_0000;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL single_eval: valid %b busy %b ready %b want 0 1 0000", rsp_valid, busy, req_ready); end
    @(negedge clk);
    #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0) begin
      tests_failed++; $display("FAIL single_rsp: valid %b tag %0d want 1 0", rsp_valid, rsp_tag); end
    tests_run++; if (rsp_sgn !== 1'b0 || rsp_exp !== 15'h3FFF || rsp_fract !== (113'd1 << 112)) begin
      tests_failed++; $display("FAIL single_fields: sgn %b exp %h fract %h want 0 3fff 1<<112", rsp_sgn, rsp_exp, rsp_fract); end
    tests_run++; if (flags !== 8'b0100_0000) begin tests_failed++; $display("FAIL single_flags: got %b want 01000000", flags); end
    @(negedge clk);
    #1;
    tests_run++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_idle: valid %b busy %b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ready;
    apply_reset();
    for (int k = 0; k < 4; k++) req_op[k*128 +: 128] = op_of(k);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL cont_first_grant: got %b want 0001", req_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL cont_eval_%0d: rsp_valid %b want 0", i, rsp_valid); end
      @(negedge clk);
      if (i == 4) req_valid = 4'b0000;
      exp_ready = (i == 4) ? 4'b0000 : (4'b0001 << ((i + 1) % 4));
      #1;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'((i % 4)) || rsp_o !== op_of(i % 4)) begin
        tests_failed++; $display("FAIL cont_rsp_%0d: valid %b tag %0d op %h want 1 %0d %h", i, rsp_valid, rsp_tag, rsp_o, i % 4, op_of(i % 4)); end
      tests_run++; if (req_ready !== exp_ready) begin
        tests_failed++; $display("FAIL cont_grant_%0d: got %b want %b", i, req_ready, exp_ready); end
    end
    @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cont_idle: busy %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd2 || rsp_o !== op_of(2) || req_ready !== 4'b0000) begin
        tests_failed++; $display("FAIL bp_hold_%0d: valid %b tag %0d op %h ready %b want 1 2 %h 0000", c, rsp_valid, rsp_tag, rsp_o, req_ready, op_of(2)); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b1000 || rsp_tag !== 2'd2) begin
      tests_failed++; $display("FAIL bp_release: ready %b tag %0d want 1000 2", req_ready, rsp_tag); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL bp_eval: valid %b busy %b want 0 1", rsp_valid, busy); end
    @(negedge clk);
    #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd3 || rsp_o !== op_of(3)) begin
      tests_failed++; $display("FAIL bp_next_rsp: valid %b tag %0d op %h want 1 3 %h", rsp_valid, rsp_tag, rsp_o, op_of(3)); end
  endtask

  task automatic test_classify();
    logic [127:0] ops [5];
    logic [7:0]   exp_flags [5];
    logic [14:0]  exp_exps [5];
    logic [112:0] exp_fracts [5];
    logic         exp_sgns [5];
    ops[0] = 128'h7FFF_8000_0000_0000_0000_0000_0000_0000;
    ops[1] = 128'h7FFF_0000_0000_0000_0000_0000_0000_0001;
    ops[2] = 128'h7FFF_0000_0000_0000_0000_0000_0000_0000;
    ops[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    ops[4] = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
    exp_flags[0] = 8'b0000_1101; exp_exps[0] = 15'h7FFF; exp_fracts[0] = (113'd1 << 112) | (113'd1 << 111); exp_sgns[0] = 1'b0;
    exp_flags[1] = 8'b0000_1011; exp_exps[1] = 15'h7FFF; exp_fracts[1] = (113'd1 << 112) | 113'd1;         exp_sgns[1] = 1'b0;
    exp_flags[2] = 8'b0101_1000; exp_exps[2] = 15'h7FFF; exp_fracts[2] = (113'd1 << 112);                 exp_sgns[2] = 1'b0;
    exp_flags[3] = 8'b1110_0000; exp_exps[3] = 15'h0000; exp_fracts[3] = 113'd0;                          exp_sgns[3] = 1'b1;
    exp_flags[4] = 8'b1000_0000; exp_exps[4] = 15'h0000; exp_fracts[4] = 113'd1;                          exp_sgns[4] = 1'b0;
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      req_op[127:0] = ops[v]; req_valid = 4'b0001; rsp_ready = 1'b1;
      #1;
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL cls_grant_%0d: got %b want 0001", v, req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      #1;
      tests_run++; if (rsp_valid !== 1'b1 || flags !== exp_flags[v] || rsp_exp !== exp_exps[v] || rsp_fract !== exp_fracts[v] || rsp_sgn !== exp_sgns[v]) begin
        tests_failed++;
        $display("FAIL cls_%0d: valid %b flags %b exp %h fract %h sgn %b want 1 %b %h %h %b", v, rsp_valid, flags, rsp_exp, rsp_fract, rsp_sgn,
                 exp_flags[v], exp_exps[v], exp_fracts[v], exp_sgns[v]);
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    @(negedge clk);
    req_op[255:128] = op_of(1); req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rme_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0000;
    #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rme_in_eval: busy %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1110;
    #1;
    tests_run++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_o !== 128'd0) begin
      tests_failed++; $display("FAIL rme_after_reset: busy %b valid %b op %h want 0 0 0", busy, rsp_valid, rsp_o); end
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rme_ptr_zero: grant %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rme_no_stale_rsp: valid %b want 0", rsp_valid); end
    @(negedge clk);
    #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd1 || rsp_o !== op_of(1)) begin
      tests_failed++; $display("FAIL rme_served: valid %b tag %0d op %h want 1 1 %h", rsp_valid, rsp_tag, rsp_o, op_of(1)); end
  endtask

  task automatic test_drop_before_grant();
    @(negedge clk);
    req_op[127:0] = op_of(0); req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL drop_grant0: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL drop_eval_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0 || req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL drop_rsp0: valid %b tag %0d ready %b want 1 0 0000", rsp_valid, rsp_tag, req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests_run++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++; $display("FAIL drop_never_served_%0d: valid %b busy %b tag %0d want 0 0", c, rsp_valid, busy, rsp_tag); end
    end
  endtask

  // Test sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_valid    = 4'b0000;
    rsp_ready    = 1'b0;
    req_op       = 512'd0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_classify();
    test_reset_mid_eval();
    test_drop_before_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp128_decomp_arbiter.md
Name: fp128_decomp_arbiter

Overview:
- Shares one registered FP128 decompose/classify stage between NREQ requesters (e.g. the add, mul and convert front ends).
- Uses a round-robin arbiter and a 3-state sequencer that drives the stage's clock enable.
- Returns the decomposed fields, class flags and requester tag on a valid/ready response channel.
- Sits ahead of the FP128 execution units, replacing per-unit decomposers.

Parameters:
- NREQ, 4, number of requesters (1..16).
- TAGW, derived as max(1, clog2(NREQ)); localparam, not overridable. Width of the requester tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_op  in  NREQ*128  operands; requester k occupies bits [128k+127:128k]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_tag  out  TAGW  index of the requester served
- rsp_o  out  128  operand as accepted
- rsp_sgn  out  1  sign
- rsp_exp  out  15  exponent
- rsp_fract  out  113  {|exp, significand}: hidden bit restored
- rsp_xz, rsp_mz, rsp_vz, rsp_inf, rsp_xinf, rsp_qnan, rsp_snan, rsp_nan  out  1 each  class flags, defined below
- busy  out  1  state != IDLE

Behaviour:
- Class flag definitions, with e = exponent field and m = significand field:
  - xz = (e == 0)
  - mz = (m == 0)
  - vz = xz & mz
  - xinf = &e
  - inf = xinf & mz
  - nan = xinf & !mz
  - qnan = xinf & m[111]
  - snan = xinf & !m[111] & !mz
- Reset (rst_n low at a clk edge):
  - state = IDLE, rr pointer = 0.
  - rsp_valid = 0; all rsp_* data = 0; req_ready = 0; busy = 0.
  - Any in-flight operation is discarded and produces no response.
- States: IDLE, EVAL, RESP.
- Grant rule (combinational):
  - winner = the first k with req_valid[k] = 1, searching ptr, ptr+1, ... mod NREQ.
  - req_ready[winner] = 1 only when a grant is permitted: in IDLE, or in RESP with rsp_ready = 1.
  - The handshake completes in that cycle; the operand and tag are latched into the operand register.
  - On grant: ptr <= (winner + 1) mod NREQ. With no grant, ptr is unchanged.
- IDLE:
  - Grant → EVAL; otherwise stay in IDLE.
- EVAL:
  - Decompose stage ce = 1 for exactly this cycle; rsp_* data registers load at the end of the cycle.
  - Always → RESP.
  - No grants in EVAL.
- RESP:
  - rsp_valid = 1.
  - All rsp_* outputs are held stable until rsp_ready = 1.
  - On rsp_ready: if a grant occurs in the same cycle → EVAL, otherwise → IDLE. rsp_valid falls unless the next cycle is again RESP.
- Latency:
  - Accept at edge t; rsp_valid is high in the cycle after edge t+1 (2 cycles).
  - With rsp_ready tied high, throughput is one result per 2 cycles.
- req_op and req_valid may change freely once the handshake completes; the block never re-samples a granted operand.
- A requester dropping req_valid before grant is legal; that request is simply not served.
- NREQ = 1: tag is always 0; round-robin degenerates to always granting requester 0.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0. No requester waits more than NREQ grants.
- Reset takes precedence over every other event, including a simultaneous grant and rsp_ready.

Test Plan:
- Single request: req_valid = 0001, req_op[0] = 0x3FFF_0000..0 (+1.0) → req_ready = 0001 for 1 cycle. Two cycles later rsp_valid = 1, tag = 0, sgn = 0, exp = 0x3FFF, fract = 1<<112, and all flags = 0 except mz = 1.
- Contention: req_valid = 1111 held, rsp_ready = 1 → grant order 0,1,2,3,0. The tags returned match, and responses arrive every 2 cycles.
- Backpressure: rsp_ready = 0 for 5 cycles in RESP → rsp_* stable and req_ready = 0000 throughout. On rsp_ready = 1, the next grant happens in the same cycle.
- Classification sweep (one check per operand):
  - 0x7FFF_8000..0 → qnan = 1, nan = 1, xinf = 1.
  - 0x7FFF_0000..01 → snan = 1, nan = 1.
  - 0x7FFF_0000..0 → inf = 1, mz = 1.
  - 0x8000_0000..0 → sgn = 1, vz = 1, fract = 0.
  - 0x0000_0000..01 (denormal) → xz = 1, fract = 1.
- Reset mid-EVAL: rst_n low in EVAL → next cycle IDLE, rsp_valid = 0, ptr = 0. No response for the dropped operand; the next request is served normally.
- Drop before grant: req_valid[2] is pulsed only while the block is in EVAL → never granted, and no response carries tag 2.
